// File: rtl/ipm_pkg.sv
// Shared definitions for the inner-product-masking datapath: field polynomial,
// packed-bus byte selection and the unmask FSM state type.
package ipm_pkg;

  // Low byte of the AES reduction polynomial x^8 + x^4 + x^3 + x + 1 (0x11B).
  localparam logic [7:0] GF_POLY = 8'h1B;

  // Widest share vector the byte-select helper accepts; callers zero-extend.
  localparam int unsigned MAX_SHARES = 64;
  localparam int unsigned BUS_W      = MAX_SHARES * 8;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_e;

  function automatic logic [7:0] byte_sel(input logic [BUS_W-1:0] bus,
                                          input int unsigned      i);
    return bus[i*8 +: 8];
  endfunction

endpackage

// File: rtl/ipm_unmask_seq_gmul8.sv
// Combinational GF(2^8) multiplier (xy = x * y mod 0x11B), shift-and-add form.
module gmul8
  import ipm_pkg::*;
(
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [7:0] xy
);

  logic [7:0] a;
  logic [7:0] p;

  always_comb begin
    a = x;
    p = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    end
    xy = p;
  end

endmodule

// File: rtl/ipm_unmask_seq.sv
// Sequential IPM decoder: X = R_0 ^ sum_{i=1..v-1} L_i * R_i over GF(2^8),
// one shared multiplier step per cycle behind valid/ready on both sides.
module ipm_unmask_seq
  import ipm_pkg::*;
#(
  parameter int unsigned v = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [v*8-1:0] L,
  input  logic [v*8-1:0] R,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [7:0]     X
);

  localparam int unsigned IW       = (v > 1) ? $clog2(v) : 1;
  localparam logic [IW-1:0] IDX_LAST  = IW'(v - 1);
  localparam logic [IW-1:0] IDX_FIRST = (v > 1) ? IW'(1) : '0;

  state_e          state_q, state_d;
  logic [v*8-1:0]  L_q, L_d;
  logic [v*8-1:0]  R_q, R_d;
  logic [7:0]      acc_q, acc_d;
  logic [IW-1:0]   idx_q, idx_d;

  logic [7:0]      op_l, op_r, prod;

  assign op_l = byte_sel(BUS_W'(L_q), 32'(idx_q));
  assign op_r = byte_sel(BUS_W'(R_q), 32'(idx_q));

  gmul8 u_gmul8 (
    .x  (op_l),
    .y  (op_r),
    .xy (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      L_q     <= '0;
      R_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      L_q     <= L_d;
      R_q     <= R_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    L_d       = L_q;
    R_d       = R_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    X         = '0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          L_d     = L;
          R_d     = R;
          acc_d   = R[7:0];
          idx_d   = IDX_FIRST;
          state_d = (v > 1) ? ACC : DONE;
        end
      end
      ACC: begin
        acc_d = acc_q ^ prod;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        X         = acc_q;
        // Shares are wiped on hand-off so no residue survives into IDLE.
        if (out_ready) begin
          L_d     = '0;
          R_d     = '0;
          acc_d   = '0;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ipm_unmask_seq.sv
// Bench for ipm_unmask_seq: four instances (v = 1, 2, 4, 8) share one stimulus
// bus and are checked every cycle against a transaction-level reference model.
module tb_ipm_unmask_seq;

  localparam int NI = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             out_ready;
  logic [63:0]      L_b, R_b;
  logic [NI-1:0]    in_ready_w, out_valid_w;
  logic [NI-1:0][7:0] x_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    localparam int unsigned VG = 1 << g;
    ipm_unmask_seq #(.v(VG)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[g]),
      .L         (L_b[VG*8-1:0]),
      .R         (R_b[VG*8-1:0]),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready),
      .X         (x_w[g])
    );
  end

  // Carry-less 8x8 product, then polynomial long division by 0x11B.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
    for (int i = 14; i >= 8; i--) if (p[i]) p ^= 15'(9'h11B) << (i - 8);
    return p[7:0];
  endfunction

  function automatic logic [7:0] ip(input logic [63:0] l, input logic [63:0] r, input int n);
    logic [7:0] s = r[7:0];
    for (int i = 1; i < n; i++) s ^= gm(l[i*8 +: 8], r[i*8 +: 8]);
    return s;
  endfunction

  // Reference: each instance is either free, counting down its v-1 step
  // latency, or presenting its result until the consumer takes it.
  bit         m_busy [NI];
  int         m_cnt  [NI];
  logic [7:0] m_val  [NI];
  int         accepts[NI];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        m_busy[k] <= 1'b0;
        m_cnt[k]  <= 0;
        m_val[k]  <= '0;
      end else if (!m_busy[k]) begin
        if (in_valid) begin
          m_busy[k]  <= 1'b1;
          m_cnt[k]   <= (1 << k) - 1;
          m_val[k]   <= ip(L_b, R_b, 1 << k);
          accepts[k] <= accepts[k] + 1;
        end
      end else if (m_cnt[k] > 0) begin
        m_cnt[k] <= m_cnt[k] - 1;
      end else if (out_ready) begin
        m_busy[k] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int k = 0; k < NI; k++) begin
        logic       e_rdy, e_ov;
        logic [7:0] e_x;
        e_rdy = !m_busy[k];
        e_ov  = m_busy[k] && (m_cnt[k] == 0);
        e_x   = e_ov ? m_val[k] : 8'h00;
        checks++;
        if (in_ready_w[k] !== e_rdy || out_valid_w[k] !== e_ov || x_w[k] !== e_x) begin
          errors++;
          $display("FAIL cycle v=%0d t=%0t got rdy=%b ov=%b X=%h want rdy=%b ov=%b X=%h",
                   1 << k, $time, in_ready_w[k], out_valid_w[k], x_w[k], e_rdy, e_ov, e_x);
        end
      end
      if (!m_busy[3]) begin
        checks++;
        if (gen_dut[3].u_dut.L_q !== '0 || gen_dut[3].u_dut.R_q !== '0 ||
            gen_dut[3].u_dut.acc_q !== '0) begin
          errors++;
          $display("FAIL zeroize t=%0t got L_q=%h R_q=%h acc=%h want all 0", $time,
                   gen_dut[3].u_dut.L_q, gen_dut[3].u_dut.R_q, gen_dut[3].u_dut.acc_q);
        end
      end
    end
  end

  task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (in_ready_w !== '1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (in_ready_w !== '1) begin
      errors++;
      $display("FAIL wait_idle got in_ready=%b want 1111", in_ready_w);
    end
  endtask

  task automatic xact(input logic [63:0] l, input logic [63:0] r, input int k,
                      input logic [7:0] want, input int want_lat);
    int lat;
    wait_idle();
    L_b = l; R_b = r; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    lat = 0;
    while (out_valid_w[k] !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (out_valid_w[k] !== 1'b1 || lat != want_lat || x_w[k] !== want) begin
      errors++;
      $display("FAIL xact v=%0d got ov=%b lat=%0d X=%h want ov=1 lat=%0d X=%h",
               1 << k, out_valid_w[k], lat, x_w[k], want_lat, want);
    end
  endtask

  localparam logic [63:0] LV4 = 64'h0000_0000_0302_5701;
  localparam logic [63:0] RV4 = 64'h0000_0000_0101_83AA;

  initial begin
    logic [63:0] l, r;
    int base, cyc;
    foreach (accepts[k]) accepts[k] = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; L_b = '0; R_b = '0;

    chk8("model_gm_57_83", gm(8'h57, 8'h83), 8'hC1);
    chk8("model_gm_87_02", gm(8'h87, 8'h02), 8'h15);
    chk8("model_ip_v4", ip(LV4, RV4, 4), 8'h6A);
    chk8("model_ip_v2", ip(64'h8701, 64'h0287, 2), 8'h92);
    chk8("model_ip_v1", ip(64'hFF, 64'h5C, 1), 8'h5C);

    repeat (3) @(posedge clk);
    #1;
    chk8("reset_in_ready", 8'(in_ready_w), 8'h0F);
    chk8("reset_out_valid", 8'(out_valid_w), 8'h00);
    chk8("reset_x_v8", x_w[3], 8'h00);
    rst_n = 1'b1;

    xact(64'h5701, 64'h8300, 1, 8'hC1, 1);
    xact(64'h8701, 64'h0287, 1, 8'h92, 1);
    xact(LV4, RV4, 2, 8'h6A, 3);
    xact(LV4, RV4, 1, 8'h6B, 1);
    xact(64'hFF, 64'h5C, 0, 8'h5C, 0);

    // Backpressure: results held, inputs ignored.
    wait_idle();
    out_ready = 1'b0;
    L_b = 64'h1122_3344_5566_7701; R_b = 64'h99AA_BBCC_DDEE_FF10;
    in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'($urandom % 2);
      chk8("bp_x_v8", x_w[3], ip(L_b, R_b, 8));
      chk8("bp_flags", {4'(in_ready_w), 4'(out_valid_w)}, 8'h0F);
      @(posedge clk); #1;
    end
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    chk8("bp_release_flags", {4'(in_ready_w), 4'(out_valid_w)}, 8'hF0);
    in_valid = 1'b0;

    // Asynchronous reset in the middle of an accumulation.
    wait_idle();
    L_b = {$urandom, $urandom}; L_b[7:0] = 8'h01; R_b = {$urandom, $urandom};
    in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk8("arst_flags", {4'(in_ready_w), 4'(out_valid_w)}, 8'hF0);
    chk8("arst_x_v8", x_w[3], 8'h00);
    chk8("arst_acc_v8", gen_dut[3].u_dut.acc_q, 8'h00);
    @(negedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      chk8("arst_no_output", 8'(out_valid_w), 8'h00);
    end

    // Randomized traffic with random backpressure.
    base = accepts[3];
    cyc  = 0;
    while (accepts[3] - base < 1000 && cyc < 60000) begin
      @(negedge clk);
      l = {$urandom, $urandom}; l[7:0] = 8'h01;
      r = {$urandom, $urandom};
      L_b = l; R_b = r;
      in_valid  = 1'($urandom % 2);
      out_ready = ($urandom % 4) != 0;
      cyc++;
    end
    checks++;
    if (accepts[3] - base < 1000) begin
      errors++;
      $display("FAIL random_budget got %0d transactions want 1000", accepts[3] - base);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk8("drain_idle", 8'(in_ready_w), 8'h0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
